// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with registered or first-word-fall-through read,
// almost-full/almost-empty flags, occupancy count, error pulses and synchronous flush.
module fifo_sync_param #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 1,
  parameter int FWFT       = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    write,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    read,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW+1)'(AF_THRESH);
  localparam logic [AW:0] AE_C    = (AW+1)'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wrPtr_q, wrPtr_d;
  logic [AW-1:0]         rdPtr_q, rdPtr_d;
  logic [AW:0]           count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  rdOk, wrOk;

  // Flags come straight from the registered count, so full and empty are never ambiguous.
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign rdOk = read & ~empty;
  assign wrOk = write & (~full | read);

  always_comb begin
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    count_d     = count_q;
    overflow_d  = write & ~wrOk;
    underflow_d = read & ~rdOk;
    if (flush) begin
      wrPtr_d     = '0;
      rdPtr_d     = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wrOk) wrPtr_d = wrPtr_q + 1'b1;
      if (rdOk) rdPtr_d = rdPtr_q + 1'b1;
      case ({wrOk, rdOk})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage has no reset; stale contents are unreachable once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (wrOk && !flush) mem_q[wrPtr_q] <= data_in;
  end

  if (FWFT == 0) begin : gRegRead
    logic [DATA_WIDTH-1:0] dataOut_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst)       dataOut_q <= '0;
      else if (flush) dataOut_q <= '0;
      else if (rdOk)  dataOut_q <= mem_q[rdPtr_q];
    end

    assign data_out = dataOut_q;
  end else begin : gFwftRead
    assign data_out = empty ? '0 : mem_q[rdPtr_q];
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench for fifo_sync_param: a registered-read instance driven through the
// fill/drain/boundary/flush/reset sequence, plus a small FWFT instance.
module tb_fifo_sync_param;

  logic        clk;
  logic        rst;
  logic        flush0, write0, read0;
  logic [15:0] data0, dout0;
  logic        full0, empty0, af0, ae0, ovf0, unf0;
  logic [3:0]  count0;
  logic        flush1, write1, read1;
  logic [15:0] data1, dout1;
  logic        full1, empty1, af1, ae1, ovf1, unf1;
  logic [3:0]  count1;

  logic [15:0] model[$];
  logic [15:0] expQ[$];
  logic [15:0] heldDout;
  logic        expOvf, expUnf;
  logic        expectPop, popPending;
  int          nVec, nFail;

  fifo_sync_param #(.DATA_WIDTH(16), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(1), .FWFT(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush0), .write(write0), .data_in(data0), .read(read0),
    .data_out(dout0), .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .count(count0), .overflow(ovf0), .underflow(unf0)
  );

  fifo_sync_param #(.DATA_WIDTH(16), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(1), .FWFT(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush1), .write(write1), .data_in(data1), .read(read1),
    .data_out(dout1), .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .count(count1), .overflow(ovf1), .underflow(unf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a pop accepted at an edge must show the scoreboard word by the next falling edge.
  always @(posedge clk) popPending <= expectPop;

  always @(negedge clk) begin
    if (popPending) begin
      if (expQ.size() == 0) begin
        nVec++;
        nFail++;
        $display("[TB] FAIL pop_data: DUT popped with no expected word queued at %0t", $time);
      end else begin
        chk("pop_data", 32'(dout0), 32'(expQ.pop_front()));
      end
    end
  end

  task automatic checkOutput();
    int sz;
    sz = model.size();
    chk("count", 32'(count0), 32'(sz));
    chk("full", 32'(full0), 32'(sz == 8));
    chk("empty", 32'(empty0), 32'(sz == 0));
    chk("almost_full", 32'(af0), 32'(sz >= 6));
    chk("almost_empty", 32'(ae0), 32'(sz <= 1));
    chk("overflow", 32'(ovf0), 32'(expOvf));
    chk("underflow", 32'(unf0), 32'(expUnf));
    chk("data_out_hold", 32'(dout0), 32'(heldDout));
  endtask

  // One clock of stimulus on the registered-read instance, with the model stepped alongside.
  task automatic applyStimulus(input logic w, input logic [15:0] d, input logic r, input logic f);
    int sz;
    bit rdOk, wrOk;
    sz   = model.size();
    rdOk = r && (sz > 0);
    wrOk = w && ((sz < 8) || r);
    if (f) begin
      model.delete();
      heldDout  = 16'h0;
      expOvf    = 1'b0;
      expUnf    = 1'b0;
      expectPop = 1'b0;
    end else begin
      expOvf = w && !wrOk;
      expUnf = r && !rdOk;
      if (rdOk) begin
        heldDout = model.pop_front();
        expQ.push_back(heldDout);
      end
      if (wrOk) model.push_back(d);
      expectPop = rdOk;
    end
    write0 = w; data0 = d; read0 = r; flush0 = f;
    @(posedge clk);
    @(negedge clk);
    write0 = 1'b0; data0 = 16'h0; read0 = 1'b0; flush0 = 1'b0;
    expectPop = 1'b0;
    checkOutput();
  endtask

  task automatic applyFwft(input logic w, input logic [15:0] d, input logic r);
    write1 = w; data1 = d; read1 = r;
    @(posedge clk);
    @(negedge clk);
    write1 = 1'b0; data1 = 16'h0; read1 = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    chk({tag, "_count"}, 32'(count0), 32'd0);
    chk({tag, "_empty"}, 32'(empty0), 32'd1);
    chk({tag, "_full"}, 32'(full0), 32'd0);
    chk({tag, "_ae"}, 32'(ae0), 32'd1);
    chk({tag, "_af"}, 32'(af0), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf0), 32'd0);
    chk({tag, "_unf"}, 32'(unf0), 32'd0);
    chk({tag, "_dout"}, 32'(dout0), 32'd0);
    chk({tag, "_fwft_dout"}, 32'(dout1), 32'd0);
    chk({tag, "_fwft_count"}, 32'(count1), 32'd0);
  endtask

  initial begin
    nVec = 0; nFail = 0;
    rst = 1'b0;
    flush0 = 0; write0 = 0; read0 = 0; data0 = 0;
    flush1 = 0; write1 = 0; read1 = 0; data1 = 0;
    heldDout = 0; expOvf = 0; expUnf = 0; expectPop = 0;
    #3;
    checkResetValues("por");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    applyFwft(1'b1, 16'h1234, 1'b0);
    chk("fwft_show", 32'(dout1), 32'h1234);
    chk("fwft_count1", 32'(count1), 32'd1);
    applyFwft(1'b1, 16'h5678, 1'b0);
    chk("fwft_keep", 32'(dout1), 32'h1234);
    applyFwft(1'b0, 16'h0, 1'b1);
    chk("fwft_next", 32'(dout1), 32'h5678);
    applyFwft(1'b0, 16'h0, 1'b1);
    chk("fwft_empty_dout", 32'(dout1), 32'h0);
    chk("fwft_empty", 32'(empty1), 32'd1);
    applyFwft(1'b1, 16'h9ABC, 1'b1);
    chk("fwft_rw_empty_dout", 32'(dout1), 32'h9ABC);
    chk("fwft_rw_empty_unf", 32'(unf1), 32'd1);
    chk("fwft_rw_empty_count", 32'(count1), 32'd1);
    applyFwft(1'b0, 16'h0, 1'b1);
    chk("fwft_last_pop", 32'(dout1), 32'h0);
    chk("fwft_unf_clear", 32'(unf1), 32'd0);

    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 16'h0010 + 16'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0099, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 16'h0020 + 16'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hBEEF, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);

    applyStimulus(1'b1, 16'h00AA, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 16'h0100 + 16'(i), 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);

    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 16'h0030 + 16'(i), 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'hDEAD, 1'b1, 1'b1);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'h0040 + 16'(i), 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    write0 = 1'b1; data0 = 16'h0055;
    @(posedge clk);
    #2 rst = 1'b0;
    #1 checkResetValues("async");
    model.delete();
    expQ.delete();
    heldDout = 16'h0; expOvf = 1'b0; expUnf = 1'b0;
    write0 = 1'b0; data0 = 16'h0;
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b1, 16'h0066, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
